adler32_stream_engine: RTL

//  Multi-byte-per-cycle Adler-32 engine. It combines size capture, data accumulation and

---
 rtl/adler32_stream_engine.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/adler32_stream_engine.sv
// Multi-byte-per-cycle Adler-32 engine with valid/ready on size, payload and checksum.
// Define ADLER_ABORT_EN to add the abort input (drops the message in DATA or DONE).
module adler32_stream_engine #(
    parameter int NBYTES = 4,
    parameter int SIZE_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                size_valid,
    input  logic [SIZE_W-1:0]   size,
    output logic                size_ready,
    input  logic                data_valid,
    input  logic [8*NBYTES-1:0] data,
    output logic                data_ready,
    output logic                checksum_valid,
    output logic [31:0]         checksum,
    input  logic                checksum_ready,
`ifdef ADLER_ABORT_EN
    input  logic                abort,
`endif
    output logic                busy
);

    localparam logic [16:0] MOD = 17'd65521;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         a_q, a_d;
    logic [15:0]         b_q, b_d;
    logic [SIZE_W-1:0]   remaining_q, remaining_d;
    logic                checksum_valid_q, checksum_valid_d;
    logic [31:0]         checksum_q, checksum_d;

    logic [3:0]          lane_cnt;
    logic [10:0]         sum_d;
    logic [11:0]         sum_w;
    logic [15:0]         a_beat;
    logic [15:0]         b_beat;

    // 2^16 = 15 (mod 65521): fold the upper bits back in, then one conditional subtract.
    // Inputs stay below 2^20, so the folded value is always below 2*MOD.
    function automatic logic [15:0] mod_fold(input logic [19:0] x);
        logic [16:0] t;
        t = 17'(x[15:0]) + 17'(x[19:16]) * 17'd15;
        if (t >= MOD) begin
            t = t - MOD;
        end
        return t[15:0];
    endfunction

    // Per-beat update: k valid lanes, lane i carries weight (k-i) into B.
    always_comb begin
        lane_cnt = (remaining_q >= SIZE_W'(NBYTES)) ? 4'(NBYTES) : remaining_q[3:0];
        sum_d    = '0;
        sum_w    = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (4'(i) < lane_cnt) begin
                sum_d = sum_d + 11'(data[8*i +: 8]);
                sum_w = sum_w + 12'(lane_cnt - 4'(i)) * 12'(data[8*i +: 8]);
            end
        end
        a_beat = mod_fold(20'(a_q) + 20'(sum_d));
        b_beat = mod_fold(20'(b_q) + 20'(lane_cnt) * 20'(a_q) + 20'(sum_w));
    end

    always_comb begin
        state_d          = state_q;
        a_d              = a_q;
        b_d              = b_q;
        remaining_d      = remaining_q;
        checksum_valid_d = checksum_valid_q;
        checksum_d       = checksum_q;
        size_ready       = 1'b0;
        data_ready       = 1'b0;

        case (state_q)
            S_IDLE: begin
                size_ready = 1'b1;
                a_d        = 16'd1;
                b_d        = 16'd0;
                if (size_valid) begin
                    if (size == '0) begin
                        state_d          = S_DONE;
                        checksum_valid_d = 1'b1;
                        checksum_d       = 32'h0000_0001;
                    end else begin
                        remaining_d = size;
                        state_d     = S_DATA;
                    end
                end
            end
            S_DATA: begin
                data_ready = 1'b1;
                if (data_valid) begin
                    a_d         = a_beat;
                    b_d         = b_beat;
                    remaining_d = remaining_q - SIZE_W'(lane_cnt);
                    if (remaining_q == SIZE_W'(lane_cnt)) begin
                        state_d          = S_DONE;
                        checksum_valid_d = 1'b1;
                        checksum_d       = {b_beat, a_beat};
                    end
                end
            end
            S_DONE: begin
                if (checksum_ready) begin
                    state_d          = S_IDLE;
                    checksum_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef ADLER_ABORT_EN
        // Abort overrides any same-cycle data or checksum handshake.
        if (abort && (state_q != S_IDLE)) begin
            state_d          = S_IDLE;
            a_d              = 16'd1;
            b_d              = 16'd0;
            remaining_d      = '0;
            checksum_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            a_q              <= 16'd1;
            b_q              <= 16'd0;
            remaining_q      <= '0;
            checksum_valid_q <= 1'b0;
            checksum_q       <= 32'h0000_0001;
        end else begin
            state_q          <= state_d;
            a_q              <= a_d;
            b_q              <= b_d;
            remaining_q      <= remaining_d;
            checksum_valid_q <= checksum_valid_d;
            checksum_q       <= checksum_d;
        end
    end

    assign checksum_valid = checksum_valid_q;
    assign checksum       = checksum_q;
    assign busy           = (state_q != S_IDLE);

endmodule
